// File: rtl/bsr_block_mac_engine.sv
// Block-sparse (BSR) MAC engine: accumulates W*x over the non-zero blocks of one block row and
// emits BLOCK signed sums when the row's last block has been processed.
module bsr_block_mac_engine #(
  parameter int BLOCK  = 8,
  parameter int LANES  = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SAT    = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BLOCK*BLOCK*DATA_W-1:0] in_block,
  input  logic [BLOCK*DATA_W-1:0]   in_act,
  input  logic [15:0]               in_block_row,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BLOCK*ACC_W-1:0]    out_data,
  output logic [15:0]               out_block_row,
  output logic                      out_sat,
  output logic                      row_err,
  output logic                      busy
);

  localparam int GROUPS = BLOCK / LANES;
  localparam int KW     = (BLOCK > 1) ? $clog2(BLOCK) : 1;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int RW     = (BLOCK > 1) ? $clog2(BLOCK) : 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT} state_t;

  state_t                         state_reg, state_next;
  logic [BLOCK*BLOCK*DATA_W-1:0]  blk_reg;
  logic [BLOCK*DATA_W-1:0]        act_reg;
  logic                           last_reg;
  logic [15:0]                    held_row_reg;
  logic                           partial_reg;
  logic [KW-1:0]                  k_reg;
  logic [GW-1:0]                  g_reg;
  logic signed [ACC_W-1:0]        acc_reg [BLOCK];
  logic                           sat_reg;
  logic                           row_err_reg;

  logic                           accept;
  logic                           last_step;
  logic                           row_switch;
  logic signed [DATA_W-1:0]       x_k;
  logic signed [ACC_W-1:0]        lane_next [LANES];
  logic [LANES-1:0]               lane_ovf;

  assign in_ready   = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign out_valid  = (state_reg == OUTPUT);
  assign accept     = in_valid && in_ready;
  assign last_step  = (state_reg == COMPUTE) && (k_reg == KW'(BLOCK-1)) && (g_reg == GW'(GROUPS-1));
  assign row_switch = partial_reg && (in_block_row != held_row_reg);
  assign x_k        = act_reg[int'(k_reg)*DATA_W +: DATA_W];

  assign out_block_row = held_row_reg;
  assign out_sat       = sat_reg;
  assign row_err       = row_err_reg;

  for (genvar gi = 0; gi < BLOCK; gi++) begin : g_out
    assign out_data[gi*ACC_W +: ACC_W] = acc_reg[gi];
  end

  // One MAC lane per output row of the current group; the add is done one bit wider to see overflow.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [RW-1:0]             row_idx;
    logic signed [DATA_W-1:0]  w;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]   cur;
    logic signed [ACC_W:0]     sum;
    logic                      ovf;

    assign row_idx = RW'(int'(g_reg)*LANES + gi);
    assign w       = blk_reg[((int'(g_reg)*LANES + gi)*BLOCK + int'(k_reg))*DATA_W +: DATA_W];
    assign prod    = w * x_k;
    assign cur     = acc_reg[row_idx];
    assign sum     = (ACC_W+1)'(cur) + (ACC_W+1)'(prod);
    assign ovf     = sum[ACC_W] ^ sum[ACC_W-1];
    assign lane_ovf[gi]  = ovf;
    assign lane_next[gi] = (SAT != 0 && ovf) ? (sum[ACC_W] ? ACC_MIN : ACC_MAX)
                                             : sum[ACC_W-1:0];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = COMPUTE;
      COMPUTE: if (last_step) state_next = last_reg ? OUTPUT : IDLE;
      OUTPUT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      blk_reg      <= '0;
      act_reg      <= '0;
      last_reg     <= 1'b0;
      held_row_reg <= '0;
      partial_reg  <= 1'b0;
      k_reg        <= '0;
      g_reg        <= '0;
      sat_reg      <= 1'b0;
      row_err_reg  <= 1'b0;
      for (int r = 0; r < BLOCK; r++) acc_reg[r] <= '0;
    end else begin
      state_reg   <= state_next;
      row_err_reg <= 1'b0;

      if (accept) begin
        blk_reg      <= in_block;
        act_reg      <= in_act;
        last_reg     <= in_last;
        held_row_reg <= in_block_row;
        partial_reg  <= 1'b1;
        k_reg        <= '0;
        g_reg        <= '0;
        // A new row arriving over unfinished partial sums abandons them.
        if (row_switch) begin
          row_err_reg <= 1'b1;
          sat_reg     <= 1'b0;
          for (int r = 0; r < BLOCK; r++) acc_reg[r] <= '0;
        end
      end

      if (state_reg == COMPUTE) begin
        if (k_reg == KW'(BLOCK-1)) begin
          k_reg <= '0;
          g_reg <= g_reg + 1'b1;
        end else begin
          k_reg <= k_reg + 1'b1;
        end
        for (int r = 0; r < BLOCK; r++)
          if (int'(g_reg) == r / LANES) acc_reg[r] <= lane_next[r % LANES];
        if (|lane_ovf) sat_reg <= 1'b1;
      end

      if (state_reg == OUTPUT && out_ready) begin
        partial_reg <= 1'b0;
        sat_reg     <= 1'b0;
        for (int r = 0; r < BLOCK; r++) acc_reg[r] <= '0;
      end
    end
  end

  a_block_lanes: assert property (@(posedge clk) (BLOCK % LANES) == 0);
  a_out_stable:  assert property (@(posedge clk) disable iff (!rst_n)
                                  (out_valid && !out_ready) |=> $stable(out_data));

endmodule
